// File: rtl/seq_det_pkg.sv
// Shared defaults for the serial pattern detector and the fill-count width helper.
package seq_det_pkg;

  localparam int         N_DEF   = 5;
  localparam logic [4:0] PAT_DEF = 5'b10010;
  localparam int         CW_DEF  = 8;

  // Width needed to hold a fill count in the range 0..n.
  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous reset; sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with loadable pattern, overlap control and Moore output w.
// Optional match counter and match_cnt port when SEQ_DETECT_MATCH_CNT_EN is defined.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int           N   = N_DEF,
  parameter logic [N-1:0] PAT = N'(PAT_DEF),
  parameter int           CW  = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          j,
  input  logic          en,
  input  logic          overlap,
  input  logic          pat_load,
  input  logic [N-1:0]  pat_in,
  output logic          w
`ifdef SEQ_DETECT_MATCH_CNT_EN
  ,
  output logic [CW-1:0] match_cnt
`endif
);

  localparam int FW = fill_width(N);

  logic [N-1:0]  pat_q;
  logic [N-1:0]  hist_q;
  logic [FW-1:0] fill_q;
  logic          m_q;

  logic [N-1:0]  hist_d;
  logic [FW-1:0] fill_inc;
  logic          shift_en;
  logic          match_d;

  always_comb begin
    shift_en = en && !pat_load;
    hist_d   = {hist_q[N-2:0], j};
    fill_inc = (fill_q == FW'(N)) ? FW'(N) : fill_q + FW'(1);
    match_d  = shift_en && (hist_d == pat_q) && (fill_inc == FW'(N));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT;
      hist_q <= '0;
      fill_q <= '0;
      m_q    <= 1'b0;
    end else if (pat_load) begin
      pat_q  <= pat_in;
      fill_q <= '0;
      m_q    <= 1'b0;
    end else if (en) begin
      hist_q <= hist_d;
      m_q    <= match_d;
      // Non-overlapping mode forces N fresh bits before the next match.
      if (match_d && !overlap) begin
        fill_q <= '0;
      end else begin
        fill_q <= fill_inc;
      end
    end
  end

  assign w = m_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
  sat_counter #(
    .W(CW)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match_d),
    .cnt (match_cnt)
  );
`endif

endmodule
